// File: rtl/bp_update_queue.sv
// Branch resolution queue: flags mispredicts with a registered redirect and
// buffers resolved branches to train the BHT one per cycle. Optional perf counters: BP_PERF_CNT_EN.
module bp_update_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_target,
   input  logic        ex_taken,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_pc,
   output logic        ex_stall,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        upd_freeze,
   output logic        is_write,
   output logic [31:0] executed_branch_pc,
   output logic [31:0] dest_pc,
   output logic        is_taken,
`ifdef BP_PERF_CNT_EN
   output logic [31:0] perf_branch_cnt,
   output logic [31:0] perf_mispred_cnt,
`endif
   output logic        upd_valid
);

   localparam int PTR_BITS = $clog2(DEPTH);
   localparam logic [PTR_BITS:0]   FULL_CNT = (PTR_BITS + 1)'(DEPTH);
   localparam logic [PTR_BITS:0]   CNT_ONE  = (PTR_BITS + 1)'(1);
   localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(1);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
      logic        taken;
      logic        alloc;
   } entry_t;

   entry_t              r_mem [DEPTH];
   logic [PTR_BITS-1:0] r_wr_ptr;
   logic [PTR_BITS-1:0] r_rd_ptr;
   logic [PTR_BITS:0]   r_count;
   logic                r_redir_valid;
   logic [31:0]         r_redir_pc;

   entry_t      w_head;
   entry_t      w_new;
   logic        w_nempty;
   logic        w_deq;
   logic        w_enq;
   logic        w_mis;
   logic [31:0] w_redir_pc;

   always_comb begin
      w_head     = r_mem[r_rd_ptr];
      w_nempty   = (r_count != '0);
      w_deq      = w_nempty && !upd_freeze;
      // A full queue still accepts when the head leaves on the same edge.
      ex_stall   = (r_count == FULL_CNT) && !w_deq;
      w_enq      = ex_valid && !ex_stall;
      w_mis      = (ex_taken != ex_pred_taken) ||
                   (ex_taken && ex_pred_taken && (ex_pred_pc != ex_target));
      w_redir_pc = ex_taken ? ex_target : (ex_pc + 32'd4);
      // Only taken branches allocate; not-taken ones just train existing entries.
      w_new.pc     = ex_pc;
      w_new.target = ex_target;
      w_new.taken  = ex_taken;
      w_new.alloc  = ex_taken;
   end

   always_ff @(posedge clk) begin
      if (w_enq) r_mem[r_wr_ptr] <= w_new;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Redirect is a one-cycle pulse; the queue is never flushed by it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_redir_valid <= 1'b0;
         r_redir_pc    <= 32'h0;
      end else begin
         r_redir_valid <= w_enq && w_mis;
         if (w_enq) r_redir_pc <= w_redir_pc;
      end
   end

`ifdef BP_PERF_CNT_EN
   logic [31:0] r_br_cnt;
   logic [31:0] r_mis_cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_br_cnt  <= '0;
         r_mis_cnt <= '0;
      end else begin
         if (w_enq && (r_br_cnt != 32'hFFFF_FFFF))
            r_br_cnt <= r_br_cnt + 32'd1;
         if (w_enq && w_mis && (r_mis_cnt != 32'hFFFF_FFFF))
            r_mis_cnt <= r_mis_cnt + 32'd1;
      end
   end

   assign perf_branch_cnt  = r_br_cnt;
   assign perf_mispred_cnt = r_mis_cnt;
`endif

   // Head fields read as zero when empty so nothing stale leaks after reset.
   assign redirect_valid     = r_redir_valid;
   assign redirect_pc        = r_redir_pc;
   assign upd_valid          = w_deq;
   assign is_write           = w_deq && w_head.alloc;
   assign is_taken           = w_nempty && w_head.taken;
   assign executed_branch_pc = w_nempty ? w_head.pc : 32'h0;
   assign dest_pc            = w_nempty ? w_head.target : 32'h0;

endmodule
